// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int unsigned FRAME_LEN = 11;
  // Start bit is produced by the RTS phase, so only data+parity+stop are shifted.
  localparam int unsigned TX_SHIFT_LEN = FRAME_LEN - 1;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return clk_hz / 1_000_000 * us;
  endfunction

  function automatic logic [TX_SHIFT_LEN-1:0] tx_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side valid/ready port of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge pulse.
module ps2_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta;
  logic cur;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      cur  <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      cur  <= meta;
      prev <= cur;
    end
  end

  assign dout = cur;
  assign fall = prev & ~cur;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 shifted bits and device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(TX_SHIFT_LEN - 1);

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk_i),
    .dout (clk_sync),
    .fall (clk_fall)
  );

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_data_i),
    .dout (data_sync),
    .fall (data_fall_unused)
  );

  tx_state_e               state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [TX_SHIFT_LEN-1:0] shift_q, shift_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic                    data_drive_q, data_drive_d;

  logic tmo;
  logic clk_oe_c, data_oe_c, ready_c, done_c, err_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      data_drive_q <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      data_drive_q <= data_drive_d;
    end
  end

  always_comb begin
    state_d      = state;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    data_drive_d = data_drive_q;
    clk_oe_c     = 1'b0;
    data_oe_c    = 1'b0;
    ready_c      = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    tmo          = (cnt == TIMEOUT_LAST) && !clk_fall;

    case (state)
      IDLE: begin
        ready_c      = 1'b1;
        bitcnt_d     = '0;
        data_drive_d = 1'b0;
        if (tx.tx_valid) begin
          shift_d = tx_frame(tx.tx_data);
          state_d = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_c = 1'b1;
        if (cnt == INHIBIT_LAST) state_d = RTS;
      end

      RTS: begin
        if (tmo) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else begin
          clk_oe_c     = 1'b1;
          data_oe_c    = 1'b1;
          data_drive_d = 1'b1;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        if (tmo) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else begin
          data_oe_c = data_drive_q;
          if (clk_fall) begin
            data_drive_d = ~shift_q[0];
            shift_d      = shift_q >> 1;
            bitcnt_d     = bitcnt_q + 4'd1;
            if (bitcnt_q == LAST_BIT) state_d = ACK;
          end
        end
      end

      ACK: begin
        if (tmo) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (clk_fall) begin
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            err_c   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (tmo) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (clk_sync && data_sync) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // One counter serves both phases: inhibit length ignores the clock edges we cause ourselves.
    if (state == IDLE || state_d != state || (clk_fall && state != INHIBIT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  // Synchronous reset is also applied combinationally so the lines release in the rst cycle itself.
  assign ps2_clk_oe  = clk_oe_c & ~rst;
  assign ps2_data_oe = data_oe_c & ~rst;
  assign tx.tx_ready = ready_c | rst;
  assign tx.busy     = (state != IDLE) & ~rst;
  assign tx.done     = done_c & ~rst;
  assign tx.err      = err_c & ~rst;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model.
module tb_ps2_host_tx;

  localparam int INHIBIT_CYCLES = 100;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_oe, data_oe;
  logic ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (bus),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, rdy_busy_cnt = 0;
  int er_cyc = 0, last_fall_cyc = 0;
  logic dn_ready, dn_next_ready, dn_next_busy, dn_arm = 1'b0;
  logic er_ready, er_next_ready, er_arm = 1'b0;
  logic [1:0] er_oe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (bus.tx_valid && bus.tx_ready && !rst) acc_cnt++;
    if (bus.busy && bus.tx_ready) rdy_busy_cnt++;
    if (dn_arm) begin
      dn_next_ready = bus.tx_ready;
      dn_next_busy  = bus.busy;
      dn_arm        = 1'b0;
    end
    if (er_arm) begin
      er_next_ready = bus.tx_ready;
      er_arm        = 1'b0;
    end
    if (bus.done) begin
      done_cnt++;
      dn_ready = bus.tx_ready;
      dn_arm   = 1'b1;
    end
    if (bus.err) begin
      err_cnt++;
      er_ready = bus.tx_ready;
      er_oe    = {clk_oe, data_oe};
      er_cyc   = cyc;
      er_arm   = 1'b1;
    end
  end

  task automatic start_tx(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) begin
      tests++; fails++;
      $display("FAIL start_tx_wait: tx_ready=%b required 1", bus.tx_ready);
    end
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_shift();
    int n = 0;
    while (!(!clk_oe && data_oe) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(!clk_oe && data_oe)) begin
      tests++; fails++;
      $display("FAIL wait_shift: clk_oe=%b data_oe=%b required 0/1", clk_oe, data_oe);
    end
  endtask

  // Keyboard model: clocks nclk bits, sampling the data line late in each low phase.
  task automatic dev_frame(input int nclk, input bit ack, output logic [9:0] bits);
    bits = '0;
    wait_shift();
    repeat (5) @(negedge clk);
    for (int k = 0; k < nclk; k++) begin
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bits[k]     = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (nclk == 10) begin
      dev_data_low = ack;
      repeat (5) @(negedge clk);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int base, input int bound);
    int n = 0;
    while (done_cnt + err_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt + err_cnt == base) begin
      tests++; fails++;
      $display("FAIL wait_end: no done/err within %0d cycles", bound);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.tx_ready, bus.busy, bus.done, bus.err, clk_oe, data_oe} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 100000",
               {bus.tx_ready, bus.busy, bus.done, bus.err, clk_oe, data_oe});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.tx_ready, bus.busy, clk_oe, data_oe} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_idle: got %b required 1000", {bus.tx_ready, bus.busy, clk_oe, data_oe});
    end
  endtask

  task automatic test_send_ed();
    int d0 = done_cnt, e0 = err_cnt, n = 0;
    logic [9:0] bits;
    start_tx(8'hED);
    while (clk_oe && !data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== INHIBIT_CYCLES) begin
      fails++;
      $display("FAIL inhibit_len: got %0d required %0d", n, INHIBIT_CYCLES);
    end
    tests++;
    if ({clk_oe, data_oe} !== 2'b11) begin
      fails++;
      $display("FAIL rts_phase: got %b required 11", {clk_oe, data_oe});
    end
    @(negedge clk);
    tests++;
    if ({clk_oe, data_oe} !== 2'b01) begin
      fails++;
      $display("FAIL shift_entry: got %b required 01", {clk_oe, data_oe});
    end
    dev_frame(10, 1'b1, bits);
    tests++;
    if (bits !== 10'h3ED) begin
      fails++;
      $display("FAIL bits_ed: got %h required 3ed", bits);
    end
    wait_end(d0 + e0, 200);
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      fails++;
      $display("FAIL done_ed: done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
    tests++;
    if ({dn_ready, dn_next_ready, dn_next_busy} !== 3'b010) begin
      fails++;
      $display("FAIL ready_after_done: got %b required 010", {dn_ready, dn_next_ready, dn_next_busy});
    end
  endtask

  task automatic test_send_f4();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] bits;
    start_tx(8'hF4);
    dev_frame(10, 1'b1, bits);
    tests++;
    if (bits !== 10'h2F4) begin
      fails++;
      $display("FAIL bits_f4: got %h required 2f4", bits);
    end
    wait_end(d0 + e0, 200);
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      fails++;
      $display("FAIL done_f4: done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, e0 = err_cnt, a0 = acc_cnt, rb0 = rdy_busy_cnt;
    logic [9:0] bits;
    start_tx(8'h00);
    repeat (10) @(negedge clk);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus.tx_valid = 1'b0;
    dev_frame(10, 1'b1, bits);
    tests++;
    if (bits !== 10'h300) begin
      fails++;
      $display("FAIL bits_00: got %h required 300", bits);
    end
    wait_end(d0 + e0, 200);
    start_tx(8'hFF);
    dev_frame(10, 1'b1, bits);
    tests++;
    if (bits !== 10'h3FF) begin
      fails++;
      $display("FAIL bits_ff: got %h required 3ff", bits);
    end
    wait_end(d0 + e0 + 1, 200);
    tests++;
    if (done_cnt - d0 !== 2 || err_cnt !== e0) begin
      fails++;
      $display("FAIL done_b2b: done=%0d err=%0d required 2 0", done_cnt - d0, err_cnt - e0);
    end
    tests++;
    if (acc_cnt - a0 !== 2) begin
      fails++;
      $display("FAIL accept_count: got %0d required 2", acc_cnt - a0);
    end
    tests++;
    if (rdy_busy_cnt !== rb0) begin
      fails++;
      $display("FAIL ready_while_busy: got %0d cycles required 0", rdy_busy_cnt - rb0);
    end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] bits;
    start_tx(8'h55);
    dev_frame(10, 1'b0, bits);
    tests++;
    if (bits !== 10'h355) begin
      fails++;
      $display("FAIL bits_55: got %h required 355", bits);
    end
    wait_end(d0 + e0, 200);
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt !== d0) begin
      fails++;
      $display("FAIL nack_err: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
    tests++;
    if ({er_oe, er_ready, er_next_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL nack_lines: got %b required 0001", {er_oe, er_ready, er_next_ready});
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] bits;
    start_tx(8'hF4);
    dev_frame(4, 1'b0, bits);
    tests++;
    if (bits[3:0] !== 4'h4) begin
      fails++;
      $display("FAIL bits_partial: got %h required 4", bits[3:0]);
    end
    wait_end(d0 + e0, TIMEOUT_CYCLES + 500);
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt !== d0) begin
      fails++;
      $display("FAIL timeout_err: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
    // Pin edge reaches the DUT's fall pulse two cycles later through the synchronizer.
    tests++;
    if (er_cyc - last_fall_cyc !== TIMEOUT_CYCLES + 2) begin
      fails++;
      $display("FAIL timeout_len: got %0d required %0d", er_cyc - last_fall_cyc, TIMEOUT_CYCLES + 2);
    end
    tests++;
    if ({er_oe, er_next_ready} !== 3'b001) begin
      fails++;
      $display("FAIL timeout_lines: got %b required 001", {er_oe, er_next_ready});
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] bits;
    start_tx(8'hA5);
    dev_frame(5, 1'b0, bits);
    tests++;
    if ({bits[4:0], data_oe} !== 6'b001011) begin
      fails++;
      $display("FAIL pre_reset: got %b required 001011", {bits[4:0], data_oe});
    end
    dev_clk_low = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.tx_ready, bus.busy, clk_oe, data_oe} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_at_fall6: got %b required 1000", {bus.tx_ready, bus.busy, clk_oe, data_oe});
    end
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.tx_ready, bus.busy, clk_oe, data_oe} !== 4'b1000 || done_cnt !== d0 || err_cnt !== e0) begin
      fails++;
      $display("FAIL after_reset: got %b done=%0d err=%0d required 1000 0 0",
               {bus.tx_ready, bus.busy, clk_oe, data_oe}, done_cnt - d0, err_cnt - e0);
    end
    start_tx(8'hFF);
    dev_frame(10, 1'b1, bits);
    tests++;
    if (bits !== 10'h3FF) begin
      fails++;
      $display("FAIL bits_ff_post_reset: got %h required 3ff", bits);
    end
    wait_end(d0 + e0, 200);
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      fails++;
      $display("FAIL done_post_reset: done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_send_ed();
    test_send_f4();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same two open-drain wires the keyboard receiver listens on. It runs on the system clock, oversamples the keyboard clock, and handles inhibit, request-to-send, bit shifting, odd parity, stop and device ACK. It reports completion or error through a valid/ready command port.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
INHIBIT_US, 100, time the PS/2 clock is held low before request-to-send (>=100 us).
TIMEOUT_US, 15000, maximum wait for any expected PS/2 clock edge before aborting.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
tx_data  in  8  command byte.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high in IDLE only; transfer accepted when tx_valid && tx_ready.
busy  out  1  high from acceptance until done/err pulse.
done  out  1  one-cycle pulse: byte sent and device ACK seen.
err  out  1  one-cycle pulse: timeout or missing ACK.
ps2_clk_i  in  1  raw PS/2 clock pin (asynchronous).
ps2_data_i  in  1  raw PS/2 data pin (asynchronous).
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release (pulled high).
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release.

Behaviour:
- Reset, and any cycle with rst=1, including mid-transfer: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 (state IDLE), busy=0, done=0, err=0, counters and shift register cleared. Lines are released in the first cycle rst is high.
- Both PS/2 inputs pass through 2-flop synchronizers. fall = sync_prev & ~sync_cur on the clock line. Edge detection is active in every state.
- INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US. TIMEOUT_CYCLES uses the same formula with TIMEOUT_US. Use $clog2-sized counters.
- Shift register (10 bits) loaded on acceptance with {1'b1 stop, ~^tx_data odd parity, tx_data}; LSB is sent first.
- States:
  - IDLE: tx_ready=1. On tx_valid, latch the frame and go to INHIBIT.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: data_oe=1 (start bit 0) for 1 cycle with clk_oe still 1, then clk_oe=0 and go to SHIFT. Data stays driven low.
  - SHIFT: on each fall, data_oe = ~shift[0], shift right, and increment bitcnt. Falls 1-8 send data bits, fall 9 sends parity, fall 10 sends stop (data_oe=0). Go to ACK after fall 10.
  - ACK: on the next fall, sample sync data. If 0, go to WAIT_IDLE. If 1, pulse err and go to IDLE.
  - WAIT_IDLE: wait until sync clk=1 and data=1, then pulse done and go to IDLE.
- Timeout: the counter resets on every fall and on every state entry. In RTS, SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES does the following in the same cycle: release both lines, pulse err, go to IDLE.
- done and err are mutually exclusive. tx_ready is low in the done/err cycle and returns high the cycle after.
- tx_valid while busy is ignored (no queueing); the upstream holds it.
- Device-initiated activity in IDLE is ignored; the receiver block handles it.
- Latency from acceptance to the start of RTS: exactly INHIBIT_CYCLES+1 cycles.

Decomposition:
- Package ps2_pkg:
  - State enum: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
  - Command constants: CMD_SET_LEDS 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, RESP_ACK 8'hFA.
  - Frame length 11.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge pulse. It is also reused by the receiver rewrite.

Test Plan:
- CLK_FREQ_HZ=1_000_000, INHIBIT_US=100. Send 0xED.
  - Required: clk_oe high for exactly 100 cycles, then data_oe goes 1.
  - Bits seen on falls 1-8 are 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - Device model ACKs, and done pulses once.
- Send 0xF4: data bits 0,0,1,0,1,1,1,1; parity 0 -> done.
- Send 0x00 then 0xFF back-to-back: parity 1 both times. tx_ready stays low in between, and a second tx_valid during busy is not accepted.
- Device model leaves data high on fall 11 -> err pulse, no done, both oe=0, and IDLE the next cycle.
- Device model stops clocking after fall 4 -> err exactly TIMEOUT_CYCLES after the last fall, and both lines released.
- Assert rst during SHIFT at fall 6 -> both oe=0 in that cycle, tx_ready=1 and busy=0 after rst drops. A new 0xFF transfer then completes normally.
